lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit for the MEM stage of the 5-stage rv32i pipeline.
- Consumes the EX-MEM register's memory request: address, store data, funct3 and load/store flags.
- Drives the data-memory handshake port (addr/wr/rd/mask/data, valid-response) and formats load results with sign/zero extension for MEM-WB.
- Stalls the pipeline while a memory access is outstanding; flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles waiting for ip_data_valid before abort; must be 1..(2^TIMEOUT_W)-1.
- TIMEOUT_W, 8: width of the wait counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ex_mem_valid  in  1  MEM-stage instruction present
- ex_mem_is_load  in  1  instruction is a load
- ex_mem_is_store  in  1  instruction is a store (never both with is_load)
- ex_mem_funct3  in  3  LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- ex_mem_addr  in  32  effective byte address
- ex_mem_store_data  in  32  rs2 value, already forwarded
- op_data_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- op_data_wr  out  1  write request
- op_data_rd  out  1  read request
- op_data_mask  out  4  byte enables
- op_data_from_proc  out  32  lane-aligned store data
- ip_data_valid  in  1  dmem completion, one-cycle pulse
- ip_data_from_dmem  in  32  read word, valid with ip_data_valid
- stall  out  1  hold IF..MEM stage registers this cycle
- load_data  out  32  extended load result
- load_done  out  1  load_data valid (one cycle)
- access_fault  out  1  misaligned/illegal/timeout (one cycle)

Behaviour:
- Reset values: all registered outputs 0, state IDLE, wait counter 0. stall, load_done and access_fault are 0 during reset.
- Reset mid-operation aborts the access. rd/wr deassert at the reset edge. A late ip_data_valid after reset is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE, legal access (ex_mem_valid & (is_load|is_store), legal funct3, aligned):
  - stall=1 combinationally.
  - Next edge: register addr, mask, data and byte offset; set op_data_rd=is_load, op_data_wr=is_store; go to BUSY; counter cleared.
- IDLE, no request: stall=0, no memory activity.
- Alignment and legality rules:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]!=0 is misaligned.
  - Store funct3 other than 000/001/010, or load funct3 011/110/111, is illegal.
  - Misaligned or illegal access: access_fault=1 combinationally, stall=0, no memory request issued, FSM stays IDLE.
- BUSY:
  - Outputs held stable; stall=1; counter increments each cycle.
  - On ip_data_valid=1: the load result is registered into load_data; rd/wr deassert at that edge; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without valid: rd/wr deassert; go to DONE with a fault flag.
  - If valid and timeout occur in the same cycle, valid wins.
- DONE:
  - stall=0 for exactly one cycle; the MEM instruction advances at this edge.
  - load_done=1 if the access was a load and not faulted; access_fault=1 if timed out.
  - Next state IDLE unconditionally. The still-present request is not re-accepted in DONE.
- Minimum occupancy: accept cycle + one BUSY cycle (valid earliest in the first BUSY cycle) + DONE, i.e. two stall cycles.
- Store formatting (off = addr[1:0]):
  - SB: mask = 4'b0001<<off; data = byte[7:0] replicated ×4.
  - SH: mask = off[1] ? 4'b1100 : 4'b0011; data = halfword replicated ×2.
  - SW: mask = 4'b1111; data unchanged.
  - Loads: mask = 4'b1111 (full word read).
- Load extraction uses the registered offset:
  - LB/LBU: select byte at off, then sign- or zero-extend.
  - LH/LHU: select the halfword chosen by off[1], then sign- or zero-extend.
  - LW: full word.
- load_data holds its value until the next completed load.

Test Plan:
- Aligned word load and store:
  - SW addr=0x104, data=0xDEADBEEF, valid after 1 cycle → mask=1111, addr=0x104, wr high for exactly one cycle, stall high for 2 cycles.
  - LW from 0x104, dmem returns 0xDEADBEEF → load_done pulse, load_data=0xDEADBEEF.
- Byte/half extraction, dmem word 0x80FF7F01:
  - LB addr=0x3 → 0xFFFFFF80.
  - LBU addr=0x3 → 0x00000080.
  - LH addr=0x2 → 0xFFFF80FF.
  - LHU addr=0x0 → 0x00007F01.
- Store lanes, data=0x000000AB:
  - SB addr=0x2 → mask=0100, data=0xABABABAB.
  - SH addr=0x2, data=0x1234 → mask=1100, data=0x12341234.
- Misaligned and illegal accesses:
  - LW addr=0x102 → access_fault pulse, stall=0, rd/wr stay 0.
  - SH addr=0x101 → same response.
  - Load funct3=011 → same response.
- Wait-state and timeout:
  - valid delayed 5 cycles → stall held 6 cycles, addr/mask stable throughout.
  - valid never arrives, TIMEOUT_CYCLES=4 → access_fault in DONE after 4 BUSY cycles, rd dropped.
- Reset while BUSY → rd=0 the next cycle, state IDLE; a subsequent ip_data_valid produces no load_done.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: data-memory handshake between the LSU and dmem
interface lsu_mem_stage_if;
  logic [31:0] op_data_addr;
  logic        op_data_wr;
  logic        op_data_rd;
  logic [3:0]  op_data_mask;
  logic [31:0] op_data_from_proc;
  logic        ip_data_valid;
  logic [31:0] ip_data_from_dmem;
  modport master (
    output op_data_addr, op_data_wr, op_data_rd, op_data_mask, op_data_from_proc,
    input  ip_data_valid, ip_data_from_dmem
  );
  modport slave (
    input  op_data_addr, op_data_wr, op_data_rd, op_data_mask, op_data_from_proc,
    output ip_data_valid, ip_data_from_dmem
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit driving the data-memory handshake
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_mem_valid,
  input  logic                  ex_mem_is_load,
  input  logic                  ex_mem_is_store,
  input  logic [2:0]            ex_mem_funct3,
  input  logic [31:0]           ex_mem_addr,
  input  logic [31:0]           ex_mem_store_data,
  lsu_mem_stage_if.master       dmem,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  load_done,
  output logic                  access_fault
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  state_t               state;
  logic [TIMEOUT_W-1:0] cnt;
  logic [1:0]           off;
  logic [2:0]           f3;
  logic                 is_ld;
  logic                 timed_out;
  logic                 req;
  logic                 illegal;
  logic                 misaligned;
  logic                 bad;
  logic                 accept;
  logic [31:0]          st_data;
  logic [3:0]           st_mask;
  logic [31:0]          ld_shift;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [31:0]          ld_ext;
  // Request legality, store lane formatting, load extraction and stall/fault outputs
  always_comb begin
    req        = ex_mem_valid & (ex_mem_is_load | ex_mem_is_store);
    illegal    = ex_mem_is_store ? (ex_mem_funct3[2] | (ex_mem_funct3[1:0] == 2'b11))
                                 : ((ex_mem_funct3[1:0] == 2'b11) | (ex_mem_funct3 == 3'b110));
    misaligned = ((ex_mem_funct3[1:0] == 2'b01) & ex_mem_addr[0]) |
                 ((ex_mem_funct3[1:0] == 2'b10) & (ex_mem_addr[1:0] != 2'b00));
    bad        = req & (illegal | misaligned);
    accept     = (state == IDLE) & req & ~bad;
    st_data    = (ex_mem_funct3[1:0] == 2'b00) ? {4{ex_mem_store_data[7:0]}} :
                 (ex_mem_funct3[1:0] == 2'b01) ? {2{ex_mem_store_data[15:0]}} : ex_mem_store_data;
    st_mask    = ex_mem_is_load ? 4'b1111 :
                 (ex_mem_funct3[1:0] == 2'b00) ? 4'b0001 << ex_mem_addr[1:0] :
                 (ex_mem_funct3[1:0] == 2'b01) ? (ex_mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ld_shift   = dmem.ip_data_from_dmem >> {off, 3'b000};
    ld_byte    = ld_shift[7:0];
    ld_half    = off[1] ? dmem.ip_data_from_dmem[31:16] : dmem.ip_data_from_dmem[15:0];
    ld_ext     = (f3 == 3'b000) ? {{24{ld_byte[7]}}, ld_byte} :
                 (f3 == 3'b100) ? {24'h0, ld_byte} :
                 (f3 == 3'b001) ? {{16{ld_half[15]}}, ld_half} :
                 (f3 == 3'b101) ? {16'h0, ld_half} : dmem.ip_data_from_dmem;
    stall        = ~reset & (accept | (state == BUSY));
    load_done    = ~reset & (state == DONE) & is_ld & ~timed_out;
    access_fault = ~reset & (((state == IDLE) & bad) | ((state == DONE) & timed_out));
  end
  // IDLE -> BUSY on a legal request, BUSY -> DONE on completion or timeout, DONE -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      cnt                    <= '0;
      off                    <= '0;
      f3                     <= '0;
      is_ld                  <= 1'b0;
      timed_out              <= 1'b0;
      load_data              <= '0;
      dmem.op_data_addr      <= '0;
      dmem.op_data_wr        <= 1'b0;
      dmem.op_data_rd        <= 1'b0;
      dmem.op_data_mask      <= '0;
      dmem.op_data_from_proc <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dmem.op_data_addr      <= {ex_mem_addr[31:2], 2'b00};
          dmem.op_data_mask      <= st_mask;
          dmem.op_data_from_proc <= st_data;
          dmem.op_data_rd        <= ex_mem_is_load;
          dmem.op_data_wr        <= ex_mem_is_store;
          off                    <= ex_mem_addr[1:0];
          f3                     <= ex_mem_funct3;
          is_ld                  <= ex_mem_is_load;
          timed_out              <= 1'b0;
          cnt                    <= '0;
          state                  <= BUSY;
        end
        BUSY: if (dmem.ip_data_valid) begin
          dmem.op_data_rd <= 1'b0;
          dmem.op_data_wr <= 1'b0;
          load_data       <= is_ld ? ld_ext : load_data;
          state           <= DONE;
        end else if (cnt == LAST) begin
          dmem.op_data_rd <= 1'b0;
          dmem.op_data_wr <= 1'b0;
          timed_out       <= 1'b1;
          state           <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed scoreboard bench for the MEM-stage load/store unit
module tb_lsu_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        ex_mem_valid = 1'b0;
  logic        v2 = 1'b0;
  logic        ex_mem_is_load = 1'b0;
  logic        ex_mem_is_store = 1'b0;
  logic [2:0]  ex_mem_funct3 = 3'b000;
  logic [31:0] ex_mem_addr = '0;
  logic [31:0] ex_mem_store_data = '0;
  logic        stall, load_done, access_fault;
  logic [31:0] load_data;
  logic        stall2, load_done2, access_fault2;
  logic [31:0] load_data2;

  lsu_mem_stage_if bus ();
  lsu_mem_stage_if bus2 ();

  lsu_mem_stage dut (
    .clk(clk), .reset(reset), .ex_mem_valid(ex_mem_valid),
    .ex_mem_is_load(ex_mem_is_load), .ex_mem_is_store(ex_mem_is_store),
    .ex_mem_funct3(ex_mem_funct3), .ex_mem_addr(ex_mem_addr),
    .ex_mem_store_data(ex_mem_store_data), .dmem(bus.master),
    .stall(stall), .load_data(load_data), .load_done(load_done),
    .access_fault(access_fault)
  );

  lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut2 (
    .clk(clk), .reset(reset), .ex_mem_valid(v2),
    .ex_mem_is_load(ex_mem_is_load), .ex_mem_is_store(ex_mem_is_store),
    .ex_mem_funct3(ex_mem_funct3), .ex_mem_addr(ex_mem_addr),
    .ex_mem_store_data(ex_mem_store_data), .dmem(bus2.master),
    .stall(stall2), .load_data(load_data2), .load_done(load_done2),
    .access_fault(access_fault2)
  );

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] d;
    logic        w;
    logic        r;
  } ev_t;
  ev_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d, input logic w, input logic r);
    ev_t e;
    e.kind = k; e.a = a; e.m = m; e.d = d; e.w = w; e.r = r;
    q.push_back(e);
  endtask

  task automatic pop(input int k, output ev_t e, output bit ok);
    ok = 1'b0;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event kind %0d: unexpected DUT output, nothing expected", k);
    end else begin
      e = q.pop_front();
      if (e.kind != k) begin
        errors++;
        $display("FAIL event order: got kind %0d expected kind %0d", k, e.kind);
      end else ok = 1'b1;
    end
  endtask

  // Monitor: every DUT output event pops the next expectation
  bit prev_req = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    bit ok;
    if (!reset) begin
      if ((bus.op_data_rd | bus.op_data_wr) && !prev_req) begin
        pop(0, e, ok);
        if (ok) begin
          check("req addr", bus.op_data_addr, e.a);
          check("req mask", {28'h0, bus.op_data_mask}, {28'h0, e.m});
          check("req wr", {31'h0, bus.op_data_wr}, {31'h0, e.w});
          check("req rd", {31'h0, bus.op_data_rd}, {31'h0, e.r});
          if (e.w) check("req data", bus.op_data_from_proc, e.d);
        end
      end
      if (load_done) begin
        pop(1, e, ok);
        if (ok) check("load_data", load_data, e.d);
      end
      if (access_fault) pop(2, e, ok);
    end
    prev_req = bus.op_data_rd | bus.op_data_wr;
  end

  task automatic run(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] w, input int dly,
                     output int stalls, output int wrc, output int rdc, output bit stable);
    logic [31:0] a0;
    logic [3:0]  m0;
    bit seen;
    bit s;
    seen = 1'b0; stalls = 0; wrc = 0; rdc = 0; stable = 1'b1; a0 = '0; m0 = '0;
    ex_mem_valid = 1'b1; ex_mem_is_load = ld; ex_mem_is_store = st;
    ex_mem_funct3 = f3; ex_mem_addr = a; ex_mem_store_data = sd;
    bus.ip_data_from_dmem = w;
    for (int c = 0; c < 300; c++) begin
      bus.ip_data_valid = (dly > 0) && (c == dly);
      @(negedge clk);
      s = stall;
      stalls += int'(stall);
      wrc += int'(bus.op_data_wr);
      rdc += int'(bus.op_data_rd);
      if (bus.op_data_rd | bus.op_data_wr) begin
        if (!seen) begin a0 = bus.op_data_addr; m0 = bus.op_data_mask; seen = 1'b1; end
        else if (a0 !== bus.op_data_addr || m0 !== bus.op_data_mask) stable = 1'b0;
      end
      @(posedge clk); #1;
      if (!s) break;
    end
    ex_mem_valid = 1'b0;
    bus.ip_data_valid = 1'b0;
  endtask

  task automatic run2(input int dly, input logic [31:0] w, output int stalls, output int rdc,
                      output bit fl, output bit ld, output bit rd_end);
    bit s;
    stalls = 0; rdc = 0; fl = 0; ld = 0; rd_end = 0;
    v2 = 1'b1; ex_mem_is_load = 1'b1; ex_mem_is_store = 1'b0;
    ex_mem_funct3 = 3'b010; ex_mem_addr = 32'h40;
    bus2.ip_data_from_dmem = w;
    for (int c = 0; c < 50; c++) begin
      bus2.ip_data_valid = (dly > 0) && (c == dly);
      @(negedge clk);
      s = stall2;
      stalls += int'(stall2);
      rdc += int'(bus2.op_data_rd);
      if (!s) begin fl = access_fault2; ld = load_done2; rd_end = bus2.op_data_rd; end
      @(posedge clk); #1;
      if (!s) break;
    end
    v2 = 1'b0;
    bus2.ip_data_valid = 1'b0;
  endtask

  initial begin
    int s, w, r;
    bit st, fl, ld, rde;
    bus.ip_data_valid = 1'b0; bus.ip_data_from_dmem = '0;
    bus2.ip_data_valid = 1'b0; bus2.ip_data_from_dmem = '0;
    ex_mem_valid = 1'b1; ex_mem_is_load = 1'b1; ex_mem_funct3 = 3'b010; ex_mem_addr = 32'h104;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset stall", {31'h0, stall}, 32'h0);
    check("reset rd", {31'h0, bus.op_data_rd}, 32'h0);
    check("reset wr", {31'h0, bus.op_data_wr}, 32'h0);
    check("reset addr", bus.op_data_addr, 32'h0);
    check("reset mask", {28'h0, bus.op_data_mask}, 32'h0);
    check("reset load_data", load_data, 32'h0);
    check("reset done/fault", {30'h0, load_done, access_fault}, 32'h0);
    ex_mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    push(0, 32'h104, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0);
    run(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1, s, w, r, st);
    check("sw stall cycles", s, 2);
    check("sw wr cycles", w, 1);

    push(0, 32'h104, 4'hF, 32'h0, 1'b0, 1'b1);
    push(1, 0, 0, 32'hDEADBEEF, 0, 0);
    run(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 1, s, w, r, st);
    check("lw rd cycles", r, 1);

    push(0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    push(1, 0, 0, 32'hFFFFFF80, 0, 0);
    run(1'b1, 1'b0, 3'b000, 32'h3, 32'h0, 32'h80FF7F01, 1, s, w, r, st);
    push(0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    push(1, 0, 0, 32'h00000080, 0, 0);
    run(1'b1, 1'b0, 3'b100, 32'h3, 32'h0, 32'h80FF7F01, 1, s, w, r, st);
    push(0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    push(1, 0, 0, 32'hFFFF80FF, 0, 0);
    run(1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 32'h80FF7F01, 1, s, w, r, st);
    push(0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    push(1, 0, 0, 32'h00007F01, 0, 0);
    run(1'b1, 1'b0, 3'b101, 32'h0, 32'h0, 32'h80FF7F01, 1, s, w, r, st);

    push(0, 32'h0, 4'b0100, 32'hABABABAB, 1'b1, 1'b0);
    run(1'b0, 1'b1, 3'b000, 32'h2, 32'h000000AB, 32'h0, 1, s, w, r, st);
    check("sb load_data held", load_data, 32'h00007F01);
    push(0, 32'h0, 4'b1100, 32'h12341234, 1'b1, 1'b0);
    run(1'b0, 1'b1, 3'b001, 32'h2, 32'h00001234, 32'h0, 1, s, w, r, st);

    push(2, 0, 0, 0, 0, 0);
    run(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1, s, w, r, st);
    check("lw misaligned stall", s, 0);
    check("lw misaligned rd/wr", w + r, 0);
    push(2, 0, 0, 0, 0, 0);
    run(1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 32'h0, 1, s, w, r, st);
    check("sh misaligned stall", s, 0);
    check("sh misaligned rd/wr", w + r, 0);
    push(2, 0, 0, 0, 0, 0);
    run(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1, s, w, r, st);
    check("ld f3=011 stall", s, 0);
    check("ld f3=011 rd/wr", w + r, 0);
    push(2, 0, 0, 0, 0, 0);
    run(1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1, s, w, r, st);
    check("st f3=100 rd/wr", w + r, 0);

    push(0, 32'h200, 4'hF, 32'h0, 1'b0, 1'b1);
    push(1, 0, 0, 32'h11223344, 0, 0);
    run(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h11223344, 5, s, w, r, st);
    check("wait stall cycles", s, 6);
    check("wait rd cycles", r, 5);
    check("wait addr/mask stable", {31'h0, st}, 32'h1);

    run2(0, 32'h0, s, r, fl, ld, rde);
    check("timeout stall cycles", s, 5);
    check("timeout busy cycles", r, 4);
    check("timeout fault", {31'h0, fl}, 32'h1);
    check("timeout no load_done", {31'h0, ld}, 32'h0);
    check("timeout rd dropped", {31'h0, rde}, 32'h0);
    run2(4, 32'h5A5A0000, s, r, fl, ld, rde);
    check("valid at limit fault", {31'h0, fl}, 32'h0);
    check("valid at limit load_done", {31'h0, ld}, 32'h1);
    check("valid at limit data", load_data2, 32'h5A5A0000);

    push(0, 32'h300, 4'hF, 32'h0, 1'b0, 1'b1);
    ex_mem_valid = 1'b1; ex_mem_is_load = 1'b1; ex_mem_is_store = 1'b0;
    ex_mem_funct3 = 3'b010; ex_mem_addr = 32'h300;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy before reset rd", {31'h0, bus.op_data_rd}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1; ex_mem_valid = 1'b0;
    @(negedge clk);
    check("in reset stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("after reset rd", {31'h0, bus.op_data_rd}, 32'h0);
    check("after reset stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    bus.ip_data_from_dmem = 32'hCAFEF00D; bus.ip_data_valid = 1'b1;
    @(negedge clk);
    check("late valid load_done", {31'h0, load_done}, 32'h0);
    @(posedge clk); #1;
    bus.ip_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("late valid load_data", load_data, 32'h0);

    push(0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    push(1, 0, 0, 32'h0000007F, 0, 0);
    run(1'b1, 1'b0, 3'b100, 32'h1, 32'h0, 32'h80FF7F01, 2, s, w, r, st);
    check("post reset stall cycles", s, 3);

    repeat (3) @(posedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
